// File: rtl/transport_packetizer_if.sv
// Word-in / byte-out stream bundle for the transport packetizer.
// master drives words and flow control, slave is the packetizer.
interface transport_packetizer_if #(
    parameter int SAMPLE_BYTES = 2
);
    logic                      in_valid;
    logic [1:0]                in_type;
    logic [8*SAMPLE_BYTES-1:0] in_data;
    logic                      in_ready;
    logic                      flush;
    logic                      send_en;
    logic                      out_ready;
    logic                      out_valid;
    logic                      out_sop;
    logic                      out_eop;
    logic [7:0]                out_data;

    modport master (
        output in_valid, in_type, in_data, flush, send_en, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_data
    );

    modport slave (
        input  in_valid, in_type, in_data, flush, send_en, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_data
    );
endinterface

// File: rtl/transport_packetizer.sv
// Packs control/audio words into fixed-size checksummed packets
// and streams them out of a byte FIFO one whole packet at a time.
module transport_packetizer #(
    parameter int PKT_BYTES    = 16,
    parameter int SAMPLE_BYTES = 2,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic clk,
    input  logic reset,
    transport_packetizer_if.slave bus,
    output logic busy,
    output logic [$clog2(FIFO_DEPTH/PKT_BYTES):0] pkt_count
);
    localparam int PAYLOAD = PKT_BYTES - 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(PKT_BYTES);
    localparam int SW = $clog2(SAMPLE_BYTES + 1);
    localparam int WW = 8 * SAMPLE_BYTES;
    localparam int CW = $clog2(FIFO_DEPTH / PKT_BYTES) + 1;

    localparam logic [IW-1:0] PAY_LAST = IW'(PAYLOAD - 1);
    localparam logic [IW-1:0] PKT_LAST = IW'(PKT_BYTES - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_BYTES - 1);
    localparam logic [AW:0]   USED_MAX = (AW+1)'(FIFO_DEPTH - PKT_BYTES);
    localparam logic [1:0]    T_CTRL   = 2'b01;
    localparam logic [1:0]    T_AUDIO  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, HDR, SER, COLLECT, PAD, CKSUM
    } state_t;

    state_t        state;
    logic [1:0]    ptype;
    logic [WW-1:0] word;
    logic [SW-1:0] sidx;
    logic [IW-1:0] pidx;
    logic [5:0]    seq;
    logic [7:0]    csum;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   used;
    logic          sending;
    logic [IW-1:0] oidx;

    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          take;
    logic          room;
    logic          close;
    logic          pop_eop;

    assign used    = wr_ptr - rd_ptr;
    assign room    = used <= USED_MAX;
    assign busy    = state != IDLE;
    assign take    = bus.in_valid && bus.in_ready;
    assign close   = state == CKSUM;
    assign pop_eop = sending && bus.out_ready && oidx == PKT_LAST;

    // A packet is only begun with a full packet of space reserved.
    always_comb begin
        bus.in_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    bus.in_ready = room;
                COLLECT: bus.in_ready = bus.in_type == T_AUDIO;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        case (state)
            HDR: begin
                wr_en   = 1'b1;
                wr_byte = {ptype, seq};
            end
            SER: begin
                wr_en   = 1'b1;
                wr_byte = word[WW-1 -: 8];
            end
            PAD:     wr_en = 1'b1;
            CKSUM: begin
                wr_en   = 1'b1;
                wr_byte = csum;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptype <= 2'b00;
            word  <= '0;
            sidx  <= '0;
            pidx  <= '0;
            seq   <= 6'd0;
            csum  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (take && (bus.in_type == T_CTRL ||
                                 bus.in_type == T_AUDIO)) begin
                        ptype <= bus.in_type;
                        word  <= bus.in_data;
                        state <= HDR;
                    end
                end
                HDR: begin
                    csum  <= wr_byte;
                    pidx  <= '0;
                    sidx  <= '0;
                    state <= SER;
                end
                SER: begin
                    csum <= csum ^ wr_byte;
                    word <= word << 8;
                    pidx <= pidx + IW'(1);
                    sidx <= sidx + SW'(1);
                    if (pidx == PAY_LAST)
                        state <= CKSUM;
                    else if (sidx == SMP_LAST)
                        state <= (ptype == T_CTRL) ? PAD : COLLECT;
                end
                COLLECT: begin
                    if (take) begin
                        word  <= bus.in_data;
                        sidx  <= '0;
                        state <= SER;
                    end else if (bus.flush) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    pidx <= pidx + IW'(1);
                    if (pidx == PAY_LAST)
                        state <= CKSUM;
                end
                CKSUM: begin
                    seq   <= seq + 6'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sending   <= 1'b0;
            oidx      <= '0;
            pkt_count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (!sending) begin
                oidx <= '0;
                if (pkt_count != '0 && bus.send_en)
                    sending <= 1'b1;
            end else if (bus.out_ready) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                oidx   <= oidx + IW'(1);
                if (oidx == PKT_LAST)
                    sending <= 1'b0;
            end
            case ({close, pop_eop})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    assign bus.out_valid = sending;
    assign bus.out_sop   = sending && oidx == '0;
    assign bus.out_eop   = sending && oidx == PKT_LAST;
    assign bus.out_data  = sending ? mem[rd_ptr[AW-1:0]] : 8'h00;
endmodule

// File: tb/tb_transport_packetizer.sv
// Scoreboard bench: a packet model queues expected bytes as words are
// accepted; a negedge monitor pops and compares every accepted byte.
module tb_transport_packetizer;
    localparam int PKT = 16;
    localparam int SB  = 2;
    localparam int FD  = 64;
    localparam int PAY = PKT - 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [2:0] pkt_count;

    transport_packetizer_if #(.SAMPLE_BYTES(SB)) bus ();

    transport_packetizer #(
        .PKT_BYTES(PKT),
        .SAMPLE_BYTES(SB),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    logic [7:0] aud_q[$];
    logic [7:0] pl_q[$];
    logic [5:0] mseq;
    logic       prev_stall;
    logic [9:0] prev_word;
    logic [7:0] last_sop;
    logic [7:0] last_eop;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic close_pkt(input logic [1:0] t);
        logic [7:0] b;
        logic [7:0] cs;
        b = {t, mseq};
        cs = b;
        exp_q.push_back({2'b10, b});
        while (pl_q.size() < PAY) pl_q.push_back(8'h00);
        foreach (pl_q[i]) begin
            cs ^= pl_q[i];
            exp_q.push_back({2'b00, pl_q[i]});
        end
        exp_q.push_back({2'b01, cs});
        pl_q.delete();
        mseq++;
    endtask

    task automatic model_word(input logic [1:0] t, input logic [15:0] d);
        if (t == 2'b01) begin
            pl_q.delete();
            pl_q.push_back(d[15:8]);
            pl_q.push_back(d[7:0]);
            close_pkt(2'b01);
        end else if (t == 2'b10) begin
            aud_q.push_back(d[15:8]);
            aud_q.push_back(d[7:0]);
            if (aud_q.size() == PAY) begin
                pl_q = aud_q;
                aud_q.delete();
                close_pkt(2'b10);
            end
        end
    endtask

    task automatic model_flush();
        if (aud_q.size() != 0) begin
            pl_q = aud_q;
            aud_q.delete();
            close_pkt(2'b10);
        end
    endtask

    task automatic send_word(input logic [1:0] t, input logic [15:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_type  = t;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 3000);
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        else model_word(t, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus.out_ready = 1'b1;
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        aud_q.delete();
        pl_q.delete();
        mseq = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_outs",
              {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_pkt_count", pkt_count, 0);
    endtask

    always @(negedge clk) begin
        logic [9:0] cur;
        logic [9:0] e;
        cur = {bus.out_sop, bus.out_eop, bus.out_data};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_word", cur, prev_word);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", cur, e);
                end
                if (bus.out_sop) last_sop = bus.out_data;
                if (bus.out_eop) last_eop = bus.out_data;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = cur;
        end
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_type   = 2'b00;
        bus.in_data   = 16'h0000;
        bus.flush     = 1'b0;
        bus.send_en   = 1'b0;
        bus.out_ready = 1'b1;
        mseq          = 6'd0;
        prev_stall    = 1'b0;
        prev_word     = '0;
        last_sop      = 8'h00;
        last_eop      = 8'h00;
        do_reset();

        bus.send_en = 1'b1;
        send_word(2'b01, 16'hABCD);
        wait_empty(0);
        check("ctrl_header", last_sop, 8'h40);
        check("ctrl_cksum", last_eop, 8'h26);

        send_word(2'b00, 16'h1111);
        send_word(2'b11, 16'h2222);
        repeat (20) @(negedge clk);
        check("ignored_busy", busy, 0);
        check("ignored_pkt_count", pkt_count, 0);

        bus.send_en = 1'b0;
        for (int i = 1; i <= 7; i++) send_word(2'b10, 16'(i));
        repeat (20) @(negedge clk);
        check("audio_pkt_count_1", pkt_count, 1);
        bus.send_en = 1'b1;
        wait_empty(0);
        check("audio_pkt_count_0", pkt_count, 0);
        check("audio_header", last_sop, 8'h81);

        for (int i = 1; i <= 3; i++) send_word(2'b10, 16'h1100 + 16'(i));
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_type  = 2'b01;
        bus.in_data  = 16'h5A5A;
        @(negedge clk);
        check("ctrl_blocked", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        check("flush_wait", n, 9);
        model_word(2'b01, 16'h5A5A);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_empty(0);

        bus.send_en = 1'b0;
        for (int i = 0; i < 14; i++)
            send_word(2'b10, 16'($urandom));
        send_word(2'b01, 16'($urandom));
        repeat (20) @(negedge clk);
        check("rand_pkt_count", pkt_count, 3);
        bus.send_en = 1'b1;
        wait_empty(1);
        check("rand_drained", pkt_count, 0);

        bus.send_en = 1'b0;
        for (int i = 0; i < 4; i++) send_word(2'b01, 16'(16'hC000 + i));
        repeat (20) @(negedge clk);
        check("full_pkt_count", pkt_count, 4);
        check("full_in_ready", bus.in_ready, 0);
        bus.send_en = 1'b1;
        for (int i = 4; i < 64; i++) send_word(2'b01, 16'(16'hC000 + i));
        wait_empty(0);
        check("wrap_drained", pkt_count, 0);

        bus.send_en = 1'b0;
        send_word(2'b01, 16'h1234);
        for (int i = 0; i < 3; i++) send_word(2'b10, 16'h7700 + 16'(i));
        repeat (4) @(negedge clk);
        check("abort_pkt_count", pkt_count, 1);
        bus.send_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check("abort_started", bus.out_valid, 1);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (20) @(negedge clk);
        check("abort_no_valid", bus.out_valid, 0);
        check("abort_pkt_count_0", pkt_count, 0);
        send_word(2'b01, 16'h0F0F);
        wait_empty(0);
        check("abort_seq_zero", last_sop, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
